// File: rtl/mem_cmd_pkg.sv
// Shared types and constants for the memory command sequencer.
//   state_t : sequencer FSM states
//   cmd_t   : one queued command {op, addr, wdata}, 12 bits
package mem_cmd_pkg;

  localparam int   ADDR_W   = 3;
  localparam int   DATA_W   = 8;
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic              op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/mem_cmd_fifo.sv
// Synchronous command FIFO.
//   i_clock/i_reset_n : clock, async active-low reset
//   i_push/i_push_data: enqueue (ignored when full)
//   i_pop/o_head      : dequeue / current head entry (ignored when empty)
//   o_full/o_empty/o_count : occupancy, all derived from the registered count
module mem_cmd_fifo
  import mem_cmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic                     i_push,
  input  cmd_t                     i_push_data,
  input  logic                     i_pop,
  output cmd_t                     o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  cmd_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only ever read after it was written.
  always_ff @(posedge i_clock) begin
    if (do_push) mem_q[wr_ptr_q] <= i_push_data;
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_count = count_q;
  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);

endmodule

// File: rtl/mem_cmd_sequencer.sv
// Command front-end for the 8-byte memory driver.
//   i_cmd_*   : command input, valid/ready, buffered in mem_cmd_fifo
//   o_rsp_*   : read response output, valid/ready
//   o_select/o_operation/o_addr/o_data : driver pins, held HOLD_CYCLES per command
//   i_mem_data: driver read data, sampled RD_LATENCY cycles after first select cycle
//   o_busy    : FIFO non-empty or FSM not idle
//
// state | meaning
// IDLE  | waiting for a queued command; pops it on the way to ISSUE
// ISSUE | select high, pins driven from the command register
// WAIT  | select low, pins held, read latency still counting
// RESP  | read response presented until accepted
module mem_cmd_sequencer
  import mem_cmd_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int RD_LATENCY  = 2
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_op,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic [ADDR_W-1:0] o_rsp_addr,
  output logic              o_select,
  output logic              o_operation,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic              o_busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int LW = $clog2(RD_LATENCY + 1);

  cmd_t          fifo_wr, fifo_head;
  logic          fifo_full, fifo_empty, fifo_pop;
  logic [CW-1:0] fifo_count;

  state_t            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic              select_q, select_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic              sample;

  assign fifo_wr = '{op: i_cmd_op, addr: i_cmd_addr, wdata: i_cmd_wdata};

  mem_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .i_push      (i_cmd_valid && o_cmd_ready),
    .i_push_data (fifo_wr),
    .i_pop       (fifo_pop),
    .o_head      (fifo_head),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty),
    .o_count     (fifo_count)
  );

  // Read data is taken on the edge where the latency counter reaches 0.
  assign sample = (state_q == ISSUE || state_q == WAIT) && (cmd_q.op == OP_READ)
                  && (lat_q == LW'(1));

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    hold_d      = hold_q;
    lat_d       = lat_q;
    select_d    = select_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    fifo_pop    = 1'b0;

    if (sample) begin
      rsp_data_d = i_mem_data;
      rsp_addr_d = cmd_q.addr;
    end

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cmd_d    = fifo_head;
          // Reads drive zero on the data pins.
          if (fifo_head.op == OP_READ) cmd_d.wdata = '0;
          hold_d   = HW'(HOLD_CYCLES);
          lat_d    = LW'(RD_LATENCY);
          select_d = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        hold_d = hold_q - HW'(1);
        if (lat_q != '0) lat_d = lat_q - LW'(1);
        if (hold_q == HW'(1)) begin
          select_d = 1'b0;
          if (cmd_q.op == OP_WRITE) begin
            state_d = IDLE;
          end else if (lat_q <= LW'(1)) begin
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (lat_q != '0) lat_d = lat_q - LW'(1);
        if (lat_q == LW'(1)) begin
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      hold_q      <= '0;
      lat_q       <= '0;
      select_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      hold_q      <= hold_d;
      lat_q       <= lat_d;
      select_q    <= select_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
    end
  end

  assign o_cmd_ready = !fifo_full;
  assign o_select    = select_q;
  assign o_operation = cmd_q.op;
  assign o_addr      = cmd_q.addr;
  assign o_data      = cmd_q.wdata;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_addr  = rsp_addr_q;
  assign o_busy      = (fifo_count != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_mem_cmd_sequencer.sv
module tb_mem_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_op = 1'b0;
  logic [2:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_ready = 1'b0;
  logic       o_cmd_ready, o_rsp_valid, o_select, o_operation, o_busy;
  logic [7:0] o_rsp_data, o_data, mem_data;
  logic [2:0] o_rsp_addr, o_addr;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_cmd_sequencer #(.DEPTH(4), .HOLD_CYCLES(2), .RD_LATENCY(2)) dut (
    .i_clock     (clk),
    .i_reset_n   (rst_n),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_op    (cmd_op),
    .i_cmd_addr  (cmd_addr),
    .i_cmd_wdata (cmd_wdata),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (o_rsp_data),
    .o_rsp_addr  (o_rsp_addr),
    .o_select    (o_select),
    .o_operation (o_operation),
    .o_addr      (o_addr),
    .o_data      (o_data),
    .i_mem_data  (mem_data),
    .o_busy      (o_busy)
  );

  // Memory behind the driver: writes land while select is high, reads are combinational.
  logic [7:0] mem [8];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
    end else if (o_select && o_operation) begin
      mem[o_addr] <= o_data;
    end
  end
  assign mem_data = mem[o_addr];

  typedef struct {
    logic       op;
    logic [2:0] addr;
    logic [7:0] data;
    int         len;
    int         start;
  } iss_t;
  typedef struct {
    logic [7:0] data;
    logic [2:0] addr;
    int         cyc;
  } rsp_t;

  iss_t iss_q[$];
  rsp_t rsp_q[$];
  iss_t cur;
  rsp_t rcur;
  int   run_len = 0;
  int   run_start = 0;
  logic prev_rv = 1'b0;

  // Logs every select pulse (pins, length, first cycle) and every new response.
  always @(negedge clk) begin
    if (o_select) begin
      if (run_len == 0) run_start = cyc;
      run_len++;
      cur.op   = o_operation;
      cur.addr = o_addr;
      cur.data = o_data;
    end else if (run_len != 0) begin
      cur.len   = run_len;
      cur.start = run_start;
      iss_q.push_back(cur);
      run_len = 0;
    end
    if (o_rsp_valid && !prev_rv) begin
      rcur.data = o_rsp_data;
      rcur.addr = o_rsp_addr;
      rcur.cyc  = cyc;
      rsp_q.push_back(rcur);
    end
    prev_rv = o_rsp_valid;
  end

  task automatic push_cmd(input logic op, input logic [2:0] a, input logic [7:0] d);
    int t = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!o_cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_vec++; n_err++;
      $display("FAIL push_timeout: ready=%0b after %0d cycles, required 1", o_cmd_ready, t);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    @(negedge clk);
    while ((o_busy || o_rsp_valid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      n_vec++; n_err++;
      $display("FAIL %s_idle_timeout: busy=%0b rsp_valid=%0b, required 0", name, o_busy, o_rsp_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int t = 0;
    int b;
    repeat (3) @(negedge clk);
    n_vec++; if (o_cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %0b exp 1", o_cmd_ready); end
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b exp 0", o_busy); end
    n_vec++; if ({o_rsp_valid, o_select, o_operation, o_addr, o_data, o_rsp_data, o_rsp_addr} !== '0) begin
      n_err++; $display("FAIL reset_outputs: rsp_valid=%0b select=%0b data=%h exp all 0", o_rsp_valid, o_select, o_data);
    end
    rst_n = 1'b1;
    b = iss_q.size();
    push_cmd(1'b1, 3'd5, 8'h5C);
    while (!o_select && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_vec++; if (o_select !== 1'b1) begin n_err++; $display("FAIL reset_issue_start: select=%0b exp 1", o_select); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (o_select !== 1'b0) begin n_err++; $display("FAIL reset_async_select: got %0b exp 0", o_select); end
    @(negedge clk);
    rst_n = 1'b1;
    n_vec++; if (o_cmd_ready !== 1'b1 || o_busy !== 1'b0 || o_rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_release: ready=%0b busy=%0b rsp_valid=%0b exp 1/0/0", o_cmd_ready, o_busy, o_rsp_valid);
    end
    repeat (5) @(negedge clk);
    n_vec++; if (o_select !== 1'b0 || o_busy !== 1'b0 || rsp_q.size() != 0) begin
      n_err++; $display("FAIL reset_cmd_dropped: select=%0b busy=%0b rsps=%0d exp 0/0/0", o_select, o_busy, rsp_q.size());
    end
    n_vec++;
    if (iss_q.size() != b + 1) begin
      n_err++; $display("FAIL reset_pulse_count: got %0d exp %0d", iss_q.size(), b + 1);
    end else if (iss_q[b].len != 1) begin
      n_err++; $display("FAIL reset_pulse_len: got %0d exp 1", iss_q[b].len);
    end
  endtask

  task automatic test_single_write();
    int b = iss_q.size();
    int br = rsp_q.size();
    push_cmd(1'b1, 3'd3, 8'hA5);
    wait_idle("single_write");
    n_vec++;
    if (iss_q.size() != b + 1) begin
      n_err++; $display("FAIL wr_pulse_count: got %0d exp %0d", iss_q.size(), b + 1);
    end else begin
      n_vec++; if (iss_q[b].len != 2) begin n_err++; $display("FAIL wr_select_len: got %0d exp 2", iss_q[b].len); end
      n_vec++; if (iss_q[b].op !== 1'b1 || iss_q[b].addr !== 3'd3 || iss_q[b].data !== 8'hA5) begin
        n_err++; $display("FAIL wr_pins: op=%0b addr=%0d data=%h exp 1/3/a5", iss_q[b].op, iss_q[b].addr, iss_q[b].data);
      end
    end
    n_vec++; if (rsp_q.size() != br) begin n_err++; $display("FAIL wr_no_rsp: rsps=%0d exp %0d", rsp_q.size(), br); end
    n_vec++; if (mem[3] !== 8'hA5) begin n_err++; $display("FAIL wr_mem: got %h exp a5", mem[3]); end
  endtask

  task automatic test_write_read();
    int b = iss_q.size();
    int br = rsp_q.size();
    rsp_ready = 1'b1;
    push_cmd(1'b1, 3'd3, 8'hA5);
    push_cmd(1'b0, 3'd3, 8'hFF);
    wait_idle("write_read");
    n_vec++;
    if (iss_q.size() != b + 2 || rsp_q.size() != br + 1) begin
      n_err++; $display("FAIL wrrd_counts: pulses=%0d rsps=%0d exp %0d/%0d", iss_q.size(), rsp_q.size(), b + 2, br + 1);
    end else begin
      n_vec++; if (iss_q[b + 1].op !== 1'b0 || iss_q[b + 1].addr !== 3'd3 || iss_q[b + 1].data !== 8'h00) begin
        n_err++; $display("FAIL rd_pins: op=%0b addr=%0d data=%h exp 0/3/00", iss_q[b + 1].op, iss_q[b + 1].addr, iss_q[b + 1].data);
      end
      n_vec++; if (iss_q[b + 1].start - iss_q[b].start != 3) begin
        n_err++; $display("FAIL wrrd_gap: got %0d exp 3", iss_q[b + 1].start - iss_q[b].start);
      end
      n_vec++; if (rsp_q[br].data !== 8'hA5 || rsp_q[br].addr !== 3'd3) begin
        n_err++; $display("FAIL rd_rsp: data=%h addr=%0d exp a5/3", rsp_q[br].data, rsp_q[br].addr);
      end
      n_vec++; if (rsp_q[br].cyc - iss_q[b + 1].start != 2) begin
        n_err++; $display("FAIL rd_latency: got %0d exp 2", rsp_q[br].cyc - iss_q[b + 1].start);
      end
    end
  endtask

  task automatic test_fifo_full();
    int b = iss_q.size();
    int br = rsp_q.size();
    int t = 0;
    int bad = 0;
    logic [2:0] exp_addr [6];
    logic       exp_op [6];
    for (int i = 0; i < 6; i++) begin
      exp_addr[i] = 3'(i);
      exp_op[i]   = (i != 0);
    end
    rsp_ready = 1'b0;
    push_cmd(1'b0, 3'd0, 8'h00);
    while (!o_rsp_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_vec++; if (o_rsp_valid !== 1'b1) begin n_err++; $display("FAIL full_stall_rsp: got %0b exp 1", o_rsp_valid); end
    for (int i = 1; i <= 4; i++) push_cmd(1'b1, 3'(i), 8'(8'h20 + i));
    n_vec++; if (o_cmd_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_low: got %0b exp 0", o_cmd_ready); end
    fork
      push_cmd(1'b1, 3'd5, 8'h25);
      begin
        repeat (6) begin
          @(negedge clk);
          if (o_cmd_ready !== 1'b0 || o_select !== 1'b0) bad++;
        end
        rsp_ready = 1'b1;
      end
    join
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL full_hold: %0d cycles with ready or select high, exp 0", bad); end
    wait_idle("fifo_full");
    n_vec++;
    if (iss_q.size() != b + 6 || rsp_q.size() != br + 1) begin
      n_err++; $display("FAIL full_counts: pulses=%0d rsps=%0d exp %0d/%0d", iss_q.size(), rsp_q.size(), b + 6, br + 1);
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_vec++;
        if (iss_q[b + i].addr !== exp_addr[i] || iss_q[b + i].op !== exp_op[i]) begin
          n_err++; $display("FAIL full_order[%0d]: op=%0b addr=%0d exp %0b/%0d", i, iss_q[b + i].op, iss_q[b + i].addr, exp_op[i], exp_addr[i]);
        end
      end
    end
    n_vec++; if (mem[5] !== 8'h25) begin n_err++; $display("FAIL full_fifth_write: got %h exp 25", mem[5]); end
  endtask

  task automatic test_addr_sweep();
    int br = rsp_q.size();
    logic [7:0] exp_d;
    rsp_ready = 1'b1;
    for (int n = 0; n < 8; n++) push_cmd(1'b1, 3'(n), 8'(16 + n));
    for (int n = 0; n < 8; n++) push_cmd(1'b0, 3'(n), 8'h00);
    wait_idle("addr_sweep");
    n_vec++;
    if (rsp_q.size() != br + 8) begin
      n_err++; $display("FAIL sweep_count: got %0d exp %0d", rsp_q.size(), br + 8);
    end else begin
      for (int n = 0; n < 8; n++) begin
        exp_d = 8'(16 + n);
        n_vec++;
        if (rsp_q[br + n].data !== exp_d || rsp_q[br + n].addr !== 3'(n)) begin
          n_err++; $display("FAIL sweep_rsp[%0d]: data=%h addr=%0d exp %h/%0d", n, rsp_q[br + n].data, rsp_q[br + n].addr, exp_d, n);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int b = iss_q.size();
    int br = rsp_q.size();
    int t = 0;
    int bad = 0;
    rsp_ready = 1'b0;
    push_cmd(1'b0, 3'd0, 8'h00);
    push_cmd(1'b0, 3'd7, 8'h00);
    while (!o_rsp_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_vec++; if (o_rsp_data !== 8'h10 || o_rsp_addr !== 3'd0) begin
      n_err++; $display("FAIL bp_first_rsp: data=%h addr=%0d exp 10/0", o_rsp_data, o_rsp_addr);
    end
    repeat (10) begin
      @(negedge clk);
      if (o_rsp_valid !== 1'b1 || o_rsp_data !== 8'h10 || o_rsp_addr !== 3'd0 || o_select !== 1'b0) bad++;
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL bp_hold_stable: %0d unstable cycles, exp 0", bad); end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (o_rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_accept_clear: got %0b exp 0", o_rsp_valid); end
    wait_idle("back_to_back");
    n_vec++;
    if (rsp_q.size() != br + 2 || iss_q.size() != b + 2) begin
      n_err++; $display("FAIL bp_counts: rsps=%0d pulses=%0d exp %0d/%0d", rsp_q.size(), iss_q.size(), br + 2, b + 2);
    end else begin
      n_vec++; if (rsp_q[br + 1].data !== 8'h17 || rsp_q[br + 1].addr !== 3'd7) begin
        n_err++; $display("FAIL bp_second_rsp: data=%h addr=%0d exp 17/7", rsp_q[br + 1].data, rsp_q[br + 1].addr);
      end
      n_vec++; if (iss_q[b + 1].start <= rsp_q[br].cyc + 10) begin
        n_err++; $display("FAIL bp_second_issue: start=%0d exp > %0d", iss_q[b + 1].start, rsp_q[br].cyc + 10);
      end
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    test_reset();
    test_single_write();
    test_write_read();
    test_fifo_full();
    test_addr_sweep();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
